// File: rtl/gcd_unit.sv
// gcd_unit: iterative greatest-common-divisor engine (subtractive algorithm).
//
// The two operands arrive one after the other on data_in: A first, then B
// on the next cycle. While the engine runs, it subtracts the smaller
// register from the larger one until the registers meet or one of them
// is zero. It then holds the result with done high until start drops.
//
// Ports
//   clk      system clock; all state changes happen on its rising edge
//   rst_n    synchronous active-low reset
//   start    level request to begin a computation (sampled in IDLE only)
//   data_in  operand bus: A during LOAD_A, B during LOAD_B
//   done     high while the result is valid (DONE state)
//   result   current contents of register A; equals the GCD while done=1
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start=1
// LOAD_A | capture operand A from data_in
// LOAD_B | capture operand B from data_in
// RUN    | one compare/subtract step per cycle
// DONE   | result valid; wait for start=0 before accepting new work

module gcd_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_gt_b;
  logic             a_eq_b;
  logic [WIDTH-1:0] diff;

  // One shared subtractor, always larger-minus-smaller, so it cannot underflow.
  assign a_gt_b = (a > b);
  assign a_eq_b = (a == b);
  assign diff   = a_gt_b ? (a - b) : (b - a);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) state <= LOAD_A;
        end
        LOAD_A: begin
          a     <= data_in;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b     <= data_in;
          state <= RUN;
        end
        RUN: begin
          if (a == '0) begin
            // gcd(0,x) = x; move B into the result register.
            a     <= b;
            state <= DONE;
            done  <= 1'b1;
          end else if ((b == '0) || a_eq_b) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (a_gt_b) begin
            a <= diff;
          end else begin
            b <= diff;
          end
        end
        DONE: begin
          // A new computation starts only after start drops and rises again.
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign result = a;

endmodule

// File: tb/tb_gcd_unit.sv
module tb_gcd_unit;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference GCD by Euclid's remainder method.
  function automatic longint gcd_ref(input longint x, input longint y);
    longint t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Subtraction count of the subtractive algorithm, derived from Euclid's
  // quotients: each division step contributes q subtractions, except the
  // last one which stops one early when the operands become equal.
  function automatic longint sub_count(input longint x, input longint y);
    longint s, q, r;
    s = 0;
    if (x == 0 || y == 0) return 0;
    while (y != 0) begin
      q = x / y;
      r = x % y;
      s += (r == 0) ? (q - 1) : q;
      x = y;
      y = r;
    end
    return s;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge after E2.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input string tag);
    start   = 1'b1;
    data_in = a;
    @(posedge clk);                       // E0
    @(negedge clk);
    chk({tag, "_done_la"}, done, 0);
    @(posedge clk);                       // E1: A loaded
    @(negedge clk);
    data_in = b;
    chk({tag, "_done_lb"}, done, 0);
    chk({tag, "_a_load"}, result, a);
    @(posedge clk);                       // E2: B loaded
    @(negedge clk);
    chk({tag, "_done_run"}, done, 0);
  endtask

  // Counts RUN edges from E3 until done; n=0 means done rose at E3.
  task automatic wait_done(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input string tag);
    longint k_exp, g_exp, n;
    bit     found;
    k_exp = sub_count(a, b);
    g_exp = gcd_ref(a, b);
    found = 1'b0;
    n     = 0;
    while (!found && n <= k_exp + 8) begin
      @(posedge clk);
      @(negedge clk);
      if (done) found = 1'b1;
      else n++;
    end
    chk({tag, "_lat"}, found ? n : -1, k_exp);
    chk({tag, "_res"}, result, g_exp);
  endtask

  // With start still high, DONE must hold; then drop start to return to IDLE.
  task automatic finish_op(input logic [WIDTH-1:0] g, input string tag);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_hold_done"}, done, 1);
    chk({tag, "_hold_res"}, result, g);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_done"}, done, 0);
  endtask

  task automatic run_case(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input string tag);
    logic [WIDTH-1:0] g;
    g = WIDTH'(gcd_ref(a, b));
    start_op(a, b, tag);
    wait_done(a, b, tag);
    finish_op(g, tag);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_done", done, 0);

    run_case(16'd143, 16'd78, "basic");
    run_case(16'd42, 16'd42, "equal");
    run_case(16'd0, 16'd25, "zero_a");
    run_case(16'd17, 16'd0, "zero_b");
    run_case(16'd0, 16'd0, "zero_ab");
    run_case(16'd100, 16'd75, "restart");

    // Reset in the middle of RUN.
    start_op(16'd143, 16'd78, "midrst");
    @(posedge clk);                       // E3
    @(posedge clk);                       // E4
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);                       // E5
    @(negedge clk);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_case(16'd48, 16'd18, "after_rst");

    for (int i = 0; i < 25; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      run_case(ra, rb, "rand");
    end

    run_case(16'd65535, 16'd1, "worst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
- Iterative greatest-common-divisor engine built from a datapath (operand registers A/B, subtractor, comparator, input mux) and an FSM controller.
- Both operands arrive sequentially on one shared input bus, A first and B on the following cycle.
- The unit computes the GCD by repeated subtraction, then presents the result together with a level done flag.
- Used as a standalone arithmetic accelerator under a simple start/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits (unsigned).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  level request to begin a computation.
- data_in  input  WIDTH  operand bus: A in LOAD_A, B in LOAD_B.
- done  output  1  high while in DONE; result is valid.
- result  output  WIDTH  current contents of register A; equals the GCD while done=1.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n=0 at a rising edge forces state=IDLE, A=0, B=0, done=0, result=0.
- Reset overrides everything, including mid-computation. Any in-flight result is discarded.
- All arithmetic is unsigned WIDTH-bit. Subtraction is only performed larger-minus-smaller, so it never underflows.
- States:
  - IDLE: done=0. If start=1 -> LOAD_A.
  - LOAD_A: A<=data_in. -> LOAD_B.
  - LOAD_B: B<=data_in. -> RUN.
  - RUN, one decision per cycle, evaluated in this priority order:
    1. A==0: A<=B, -> DONE.
    2. B==0 or A==B: -> DONE, registers unchanged.
    3. A>B: A<=A-B, stay in RUN.
    4. A<B: B<=B-A, stay in RUN.
  - DONE: done=1, A and B held. If start=0 -> IDLE; if start=1 -> stay in DONE.
- Restart handshake: a new computation requires start to drop and then rise again. start held high after completion does not retrigger.
- start is ignored in LOAD_A, LOAD_B and RUN.
- Outputs are Moore:
  - done = (state==DONE).
  - result = A at all times.
- Results for zero operands: gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0.
- Latency: let E0 be the edge that samples start=1 in IDLE.
  - A loads at E1, B at E2.
  - RUN occupies edges E3 .. E3+k, where k is the number of subtractions.
  - done rises at edge E3+k.
- Worst case is k = 2^WIDTH-2 subtractions (e.g. operands 65535 and 1).
- No other outputs. The comparator flags (lt/gt/eq) and load/select controls are internal.

Test Plan:
- Basic: rst_n=0 for 2 cycles, then release; start=1; data_in=143 for LOAD_A, 78 for LOAD_B -> A sequence 143,65,52,39,26,13 and B sequence 78,13. done=1 at E9 with result=13. With start held high, done stays 1 and result stays 13.
- Equal operands 42,42 -> RUN exits on its first edge; done at E3, result=42.
- Zero operands: (0,25) -> 25 at E3; (17,0) -> 17 at E3; (0,0) -> 0 at E3.
- Worst case 65535,1 -> done after 65534 subtractions (edge E3+65534), result=1.
- Reset mid-run: load 143,78, pull rst_n low at E5 -> next state IDLE, done=0, result=0. Then run 48,18 -> result=6, done=1.
- Restart handshake: after done, start=0 for one cycle -> IDLE with done=0. start=1 with operands 100,75 -> done=0 through LOAD_A/LOAD_B/RUN, then done=1 with result=25.
